// File: rtl/hgc_axil_cmd_arbiter.sv
// hgc_axil_cmd_arbiter: round-robin arbiter sharing one AXI4-Lite master port among NREQ command requesters
// One transaction in flight at a time; the response is steered back to the requester that owns it.
module hgc_axil_cmd_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic [ADDR_W-1:0]      M_AXI_AWADDR,
    output logic                   M_AXI_AWVALID,
    input  logic                   M_AXI_AWREADY,
    output logic [DATA_W-1:0]      M_AXI_WDATA,
    output logic [DATA_W/8-1:0]    M_AXI_WSTRB,
    output logic                   M_AXI_WVALID,
    input  logic                   M_AXI_WREADY,
    input  logic [1:0]             M_AXI_BRESP,
    input  logic                   M_AXI_BVALID,
    output logic                   M_AXI_BREADY,
    output logic [ADDR_W-1:0]      M_AXI_ARADDR,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [DATA_W-1:0]      M_AXI_RDATA,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] gnt;
    logic          gnt_any;
    logic          grant;
    int            idx;

    assign M_AXI_WSTRB = '1;

    // Walk downward so the lowest offset from ptr wins the grant.
    always_comb begin
        gnt     = ptr;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[IW'(idx)]) begin
                gnt     = IW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

    // No grant in the response cycle, so the next command starts the cycle after rsp_valid.
    assign grant     = ARESETN && state == IDLE && rsp_valid == '0 && gnt_any;
    assign req_ready = grant ? NREQ'(1) << gnt : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (grant) begin
                    owner <= gnt;
                    ptr   <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                    if (req_write[gnt]) begin
                        M_AXI_AWADDR  <= req_addr[gnt*ADDR_W +: ADDR_W];
                        M_AXI_WDATA   <= req_wdata[gnt*DATA_W +: DATA_W];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WR_AW_W;
                    end else begin
                        M_AXI_ARADDR  <= req_addr[gnt*ADDR_W +: ADDR_W];
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RD_AR;
                    end
                end
                WR_AW_W: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: if (M_AXI_BVALID) begin
                    M_AXI_BREADY <= 1'b0;
                    rsp_valid    <= NREQ'(1) << owner;
                    rsp_resp     <= M_AXI_BRESP;
                    rsp_rdata    <= '0;
                    state        <= IDLE;
                end
                RD_AR: if (M_AXI_ARREADY) begin
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b1;
                    state         <= RD_R;
                end
                RD_R: if (M_AXI_RVALID) begin
                    M_AXI_RREADY <= 1'b0;
                    rsp_valid    <= NREQ'(1) << owner;
                    rsp_resp     <= M_AXI_RRESP;
                    rsp_rdata    <= M_AXI_RDATA;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hgc_axil_cmd_arbiter.sv
// tb_hgc_axil_cmd_arbiter: random and directed requester traffic against a queue-based arbiter model
// and a behavioural AXI4-Lite register slave with random ready/response timing.
module tb_hgc_axil_cmd_arbiter;
    localparam int N = 3;

    typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} cmd_t;

    logic              tb_ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write = '0;
    logic [N*32-1:0]   req_addr = '0;
    logic [N*32-1:0]   req_wdata = '0;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [31:0]       M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [31:0]       M_AXI_RDATA = '0;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic              M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic              M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]        M_AXI_BRESP = '0, M_AXI_RRESP = '0;

    hgc_axil_cmd_arbiter #(.NREQ(N), .ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(tb_ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int n_cmp = 0, n_bad = 0;

    // requesters
    cmd_t         q [N][$];
    logic [N-1:0] rq_on = '0;
    bit           rnd_mode = 0, gapless = 0;

    // arbiter model
    int          m_ptr, m_owner;
    bit          m_busy, m_due, aw_done, w_done, ar_done;
    cmd_t        m_cmd;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata, m_exp_rd;
    logic [31:0] ref_mem [16];
    int          grant_log [$];
    logic [33:0] rsp_log [N][$];
    int          n_bhs = 0;

    // slave model
    logic [31:0] s_mem [16];
    bit          s_aw, s_w, s_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    int          s_aw_wait, s_w_wait, s_b_wait, s_ar_wait, s_r_wait;
    int          d_aw, d_w, d_b, d_ar, d_r;
    int          fix_aw = -1, fix_w = -1, fix_r = -1, force_rresp = -1;
    logic [1:0]  s_bresp, s_rresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.w = w;
        c.a = a;
        c.d = d;
        return c;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = v >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit pending();
        bit r = m_busy || m_due;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) r = 1;
        return r;
    endfunction

    task automatic new_delays();
        d_aw = fix_aw >= 0 ? fix_aw : int'($urandom_range(0, 3));
        d_w  = fix_w  >= 0 ? fix_w  : int'($urandom_range(0, 3));
        d_b  = int'($urandom_range(0, 2));
        d_ar = int'($urandom_range(0, 3));
        d_r  = fix_r  >= 0 ? fix_r  : int'($urandom_range(0, 2));
        s_aw_wait = 0; s_w_wait = 0; s_b_wait = 0; s_ar_wait = 0; s_r_wait = 0;
        s_bresp = (rnd_mode && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        s_rresp = force_rresp >= 0 ? 2'(force_rresp) :
                  (rnd_mode && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endtask

    task automatic reset_models();
        m_ptr = 0; m_busy = 0; m_due = 0; aw_done = 0; w_done = 0; ar_done = 0;
        s_aw = 0; s_w = 0; s_ar = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        rq_on = '0;
        fix_aw = -1; fix_w = -1; fix_r = -1; force_rresp = -1;
        new_delays();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!rq_on[i] && q[i].size() > 0 && (gapless || $urandom_range(0, 2) != 0)) rq_on[i] = 1'b1;
            else if (rq_on[i] && rnd_mode && $urandom_range(0, 19) == 0) rq_on[i] = 1'b0;
            req_valid[i] = rq_on[i];
            if (q[i].size() > 0) begin
                req_write[i] = q[i][0].w;
                req_addr[i*32 +: 32] = q[i][0].a;
                req_wdata[i*32 +: 32] = q[i][0].d;
            end
        end
        M_AXI_AWREADY = !s_aw && s_aw_wait >= d_aw;
        M_AXI_WREADY  = !s_w && s_w_wait >= d_w;
        M_AXI_BVALID  = s_aw && s_w && s_b_wait >= d_b;
        M_AXI_BRESP   = s_bresp;
        M_AXI_ARREADY = !s_ar && s_ar_wait >= d_ar;
        M_AXI_RVALID  = s_ar && s_r_wait >= d_r;
        M_AXI_RDATA   = s_mem[s_araddr[5:2]];
        M_AXI_RRESP   = s_rresp;
    endtask

    task automatic sample();
        logic [N-1:0] exp_rdy;
        bit was_due;
        int g;
        chk("rsp_valid", rsp_valid, m_due ? N'(1) << m_owner : '0);
        if (m_due) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_resp", rsp_resp, m_resp);
        end
        for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_log[i].push_back({rsp_resp, rsp_rdata});
        was_due = m_due;
        m_due = 0;
        if (m_busy && m_cmd.w) begin
            chk("awvalid", M_AXI_AWVALID, !aw_done);
            if (!aw_done) chk("awaddr", M_AXI_AWADDR, m_cmd.a);
            chk("wvalid", M_AXI_WVALID, !w_done);
            if (!w_done) chk("wdata", M_AXI_WDATA, m_cmd.d);
            chk("bready", M_AXI_BREADY, aw_done && w_done);
            chk("rd_side_quiet", {M_AXI_ARVALID, M_AXI_RREADY}, 0);
        end else if (m_busy) begin
            chk("arvalid", M_AXI_ARVALID, !ar_done);
            if (!ar_done) chk("araddr", M_AXI_ARADDR, m_cmd.a);
            chk("rready", M_AXI_RREADY, ar_done);
            chk("wr_side_quiet", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
        end else begin
            chk("axi_quiet", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        end
        chk("wstrb", M_AXI_WSTRB, 4'hF);
        // grant decision: idle arbiter, not the response cycle, round robin from ptr
        exp_rdy = '0;
        g = (!m_busy && !was_due) ? rr_pick(req_valid, m_ptr) : -1;
        if (g >= 0) exp_rdy = N'(1) << g;
        chk("req_ready", req_ready, exp_rdy);
        if (g >= 0 && q[g].size() > 0) begin
            m_busy = 1; m_owner = g; m_cmd = q[g][0]; m_ptr = (g + 1) % N;
            aw_done = 0; w_done = 0; ar_done = 0;
            grant_log.push_back(g);
            if (m_cmd.w) ref_mem[m_cmd.a[5:2]] = m_cmd.d;
            else m_exp_rd = ref_mem[m_cmd.a[5:2]];
        end
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i] && q[i].size() > 0) begin
            void'(q[i].pop_front());
            rq_on[i] = 1'b0;
        end
        // channel handshakes that complete at the coming edge
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin s_aw = 1; s_awaddr = M_AXI_AWADDR; aw_done = 1; end
        else if (M_AXI_AWVALID) s_aw_wait++;
        if (M_AXI_WVALID && M_AXI_WREADY) begin s_w = 1; s_wdata = M_AXI_WDATA; w_done = 1; end
        else if (M_AXI_WVALID) s_w_wait++;
        if (M_AXI_BVALID && M_AXI_BREADY) begin
            s_mem[s_awaddr[5:2]] = s_wdata;
            n_bhs++;
            m_due = 1; m_resp = M_AXI_BRESP; m_rdata = '0; m_busy = 0;
            s_aw = 0; s_w = 0;
            new_delays();
        end else if (s_aw && s_w) s_b_wait++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin s_ar = 1; s_araddr = M_AXI_ARADDR; ar_done = 1; end
        else if (M_AXI_ARVALID) s_ar_wait++;
        if (M_AXI_RVALID && M_AXI_RREADY) begin
            m_due = 1; m_resp = M_AXI_RRESP; m_rdata = m_exp_rd; m_busy = 0;
            s_ar = 0;
            new_delays();
        end else if (s_ar) s_r_wait++;
    endtask

    task automatic step();
        @(negedge tb_ACLK);
        drive();
        #1;
        sample();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        chk("drain_done", pending(), 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_resp, rsp_rdata}, 0);
        chk({tag, "_axi_ctl"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk({tag, "_axi_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        chk({tag, "_wdata"}, M_AXI_WDATA, 0);
        chk({tag, "_wstrb"}, M_AXI_WSTRB, 4'hF);
    endtask

    initial begin
        int b0;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; s_mem[i] = '0; end
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        reset_models();
        // reset: ready stays low even with every requester asking
        req_valid = '1;
        repeat (2) @(negedge tb_ACLK);
        #1 check_quiet("reset");
        @(negedge tb_ACLK);
        ARESETN = 1'b1;
        req_valid = '0;

        // 1: write then read back on requester 0
        q[0].push_back(mk(1'b1, 32'h0, 32'h0101FFFF));
        q[0].push_back(mk(1'b0, 32'h0, 32'h0));
        drain(200);
        chk("t1_rsp_count", rsp_log[0].size(), 2);
        if (rsp_log[0].size() == 2) begin
            chk("t1_write_rsp", rsp_log[0][0], {2'b00, 32'h0});
            chk("t1_read_rsp", rsp_log[0][1], {2'b00, 32'h0101FFFF});
        end

        // 2: two requesters valid continuously; ptr is 1 after two grants to requester 0
        gapless = 1;
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            q[0].push_back(mk(1'b1, 32'h10 + 32'(k * 4), $urandom()));
            q[1].push_back(mk(1'b1, 32'h20 + 32'(k * 4), $urandom()));
        end
        drain(400);
        chk("t2_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("t2_grant_order", grant_log[k], (k % 2 == 0) ? 1 : 0);

        // 3: AW accepted well before W, then the reverse
        b0 = n_bhs;
        fix_aw = 0; fix_w = 3; new_delays();
        q[2].push_back(mk(1'b1, 32'h30, 32'h5A5A0001));
        drain(200);
        fix_aw = 3; fix_w = 0; new_delays();
        q[2].push_back(mk(1'b1, 32'h34, 32'h5A5A0002));
        drain(200);
        fix_aw = -1; fix_w = -1; new_delays();
        chk("t3_b_handshakes", n_bhs - b0, 2);

        // 4: back-to-back writes, then readback
        for (int i = 0; i < N; i++) rsp_log[i].delete();
        q[1].push_back(mk(1'b1, 32'h04, 32'hABCD0001));
        q[1].push_back(mk(1'b1, 32'h08, 32'hDEAD0011));
        q[1].push_back(mk(1'b1, 32'h0C, 32'hBEEF0011));
        q[1].push_back(mk(1'b0, 32'h04, 32'h0));
        q[1].push_back(mk(1'b0, 32'h08, 32'h0));
        q[1].push_back(mk(1'b0, 32'h0C, 32'h0));
        drain(400);
        chk("t4_rsp_count", rsp_log[1].size(), 6);
        if (rsp_log[1].size() == 6) begin
            chk("t4_rd04", rsp_log[1][3], {2'b00, 32'hABCD0001});
            chk("t4_rd08", rsp_log[1][4], {2'b00, 32'hDEAD0011});
            chk("t4_rd0C", rsp_log[1][5], {2'b00, 32'hBEEF0011});
        end

        // 5: SLVERR on a read goes only to requester 1
        for (int i = 0; i < N; i++) rsp_log[i].delete();
        force_rresp = 2; new_delays();
        q[1].push_back(mk(1'b0, 32'h04, 32'h0));
        drain(200);
        force_rresp = -1; new_delays();
        chk("t5_rsp_count1", rsp_log[1].size(), 1);
        if (rsp_log[1].size() == 1) chk("t5_slverr", rsp_log[1][0], {2'b10, 32'hABCD0001});
        chk("t5_other_rsp", rsp_log[0].size() + rsp_log[2].size(), 0);

        // 6: reset pulse while waiting for read data
        for (int i = 0; i < N; i++) rsp_log[i].delete();
        fix_r = 50; new_delays();
        q[0].push_back(mk(1'b0, 32'h08, 32'h0));
        for (int c = 0; c < 60 && !M_AXI_RREADY; c++) step();
        chk("t6_in_rd_r", M_AXI_RREADY, 1);
        #2 ARESETN = 1'b0;
        req_valid = '1;
        #1 check_quiet("t6_abort");
        reset_models();
        repeat (2) @(negedge tb_ACLK);
        ARESETN = 1'b1;
        req_valid = '0;
        grant_log.delete();
        gapless = 1;
        q[1].push_back(mk(1'b0, 32'h0C, 32'h0));
        q[0].push_back(mk(1'b0, 32'h04, 32'h0));
        drain(200);
        chk("t6_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t6_first_grant", grant_log[0], 0);
            chk("t6_second_grant", grant_log[1], 1);
        end
        chk("t6_rsp0_count", rsp_log[0].size(), 1);
        if (rsp_log[0].size() == 1) chk("t6_rsp0", rsp_log[0][0], {2'b00, 32'hABCD0001});
        if (rsp_log[1].size() == 1) chk("t6_rsp1", rsp_log[1][0], {2'b00, 32'hBEEF0011});

        // random traffic with request drops, random slave timing and error responses
        gapless = 0;
        rnd_mode = 1;
        new_delays();
        for (int k = 0; k < 120; k++)
            for (int i = 0; i < N; i++)
                q[i].push_back(mk(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom()));
        drain(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
